sha256_padder: RTL and testbench

SHA256_PADDER -- requirements
Module: sha256_padder

---
 rtl/sha256_padder.sv | 167 ++++++++++++++++
 tb/tb_sha256_padder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into padded 512-bit blocks.
// Latency: a block is presented the cycle after its 16th or final word; an extra length block follows back-to-back.
// Backpressure: in_ready is high only while filling; a stalled block holds its data and blocks new words.
module sha256_padder (
   input  logic         sys_clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_data,
   input  logic         in_last,
   input  logic [2:0]   in_bytes,
   output logic         blk_valid,
   input  logic         blk_ready,
   output logic [511:0] blk_data,
   output logic         blk_last
);

   typedef enum logic [1:0] {FILL, EMIT, EXTRA} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_started;     // keeps in_ready low until the first edge after reset
   logic [31:0]   r_buf [16];
   logic [31:0]   w_buf_nxt [16];
   logic [3:0]    r_w;           // next word index to fill
   logic [63:0]   r_cnt;         // running message length in bits
   logic          r_last;        // current block is the final block
   logic          r_pend;        // a length-only extra block must follow
   logic          r_defer;       // the 0x80 marker belongs at the start of the extra block

   logic          w_acc;
   logic          w_xfer;
   logic [2:0]    w_nb;
   logic [4:0]    w_p;
   logic [63:0]   w_cnt_add;
   logic [31:0]   w_mask;
   logic [31:0]   w_pad;
   logic [31:0]   w_last_word;

   assign w_acc     = in_valid && in_ready;
   assign w_xfer    = blk_valid && blk_ready;
   // Non-last words always carry 4 bytes; oversize byte counts saturate at 4.
   assign w_nb      = (!in_last || (in_bytes > 3'd4)) ? 3'd4 : in_bytes;
   assign w_cnt_add = r_cnt + {58'd0, w_nb, 3'b000};
   // Word that receives the 0x80 marker: this word, or the next one when it is full.
   assign w_p       = {1'b0, r_w} + {4'd0, (w_nb == 3'd4)};
   assign blk_last  = r_last;

   // Byte mask and 0x80 marker for the final word, by number of valid bytes.
   always_comb begin
      w_mask = 32'hFFFF_FFFF;
      w_pad  = 32'h0000_0000;
      case (w_nb)
         3'd0:    begin w_mask = 32'h0000_0000; w_pad = 32'h8000_0000; end
         3'd1:    begin w_mask = 32'hFF00_0000; w_pad = 32'h0080_0000; end
         3'd2:    begin w_mask = 32'hFFFF_0000; w_pad = 32'h0000_8000; end
         3'd3:    begin w_mask = 32'hFFFF_FF00; w_pad = 32'h0000_0080; end
         default: begin w_mask = 32'hFFFF_FFFF; w_pad = 32'h0000_0000; end
      endcase
      w_last_word = (in_data & w_mask) | w_pad;
   end

   // FSM state register.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) r_state <= FILL;
      else     r_state <= w_state_nxt;
   end

   // FSM next state and handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      blk_valid   = 1'b0;
      unique case (r_state)
         FILL: begin
            in_ready = r_started;
            if (w_acc && (in_last || (r_w == 4'd15))) w_state_nxt = EMIT;
         end
         EMIT: begin
            blk_valid = 1'b1;
            if (w_xfer) begin
               if (!r_last && r_pend) w_state_nxt = EXTRA;
               else                   w_state_nxt = FILL;
            end
         end
         EXTRA: begin
            blk_valid = 1'b1;
            if (w_xfer) w_state_nxt = FILL;
         end
         default: w_state_nxt = FILL;
      endcase
   end

   // Next buffer contents: word writes, final-word padding, extra block load, clear after final block.
   always_comb begin
      for (int i = 0; i < 16; i++) w_buf_nxt[i] = r_buf[i];
      if (w_acc) begin
         if (!in_last) begin
            w_buf_nxt[r_w] = in_data;
         end else begin
            for (int i = 0; i < 16; i++) begin
               if (5'(i) == {1'b0, r_w}) begin
                  w_buf_nxt[i] = w_last_word;
               end else if (5'(i) > {1'b0, r_w}) begin
                  if (5'(i) == w_p)                      w_buf_nxt[i] = 32'h8000_0000;
                  else if ((w_p <= 5'd13) && (i == 14))  w_buf_nxt[i] = w_cnt_add[63:32];
                  else if ((w_p <= 5'd13) && (i == 15))  w_buf_nxt[i] = w_cnt_add[31:0];
                  else                                   w_buf_nxt[i] = 32'h0000_0000;
               end
            end
         end
      end else if (w_xfer) begin
         if (r_last) begin
            for (int i = 0; i < 16; i++) w_buf_nxt[i] = 32'h0000_0000;
         end else if (r_pend) begin
            for (int i = 0; i < 16; i++) w_buf_nxt[i] = 32'h0000_0000;
            if (r_defer) w_buf_nxt[0] = 32'h8000_0000;
            w_buf_nxt[14] = r_cnt[63:32];
            w_buf_nxt[15] = r_cnt[31:0];
         end
      end
   end

   // Datapath and control registers.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_started <= 1'b0;
         r_w       <= 4'd0;
         r_cnt     <= 64'd0;
         r_last    <= 1'b0;
         r_pend    <= 1'b0;
         r_defer   <= 1'b0;
         for (int i = 0; i < 16; i++) r_buf[i] <= 32'h0000_0000;
      end else begin
         r_started <= 1'b1;
         for (int i = 0; i < 16; i++) r_buf[i] <= w_buf_nxt[i];
         if (w_acc) begin
            r_cnt <= w_cnt_add;
            r_w   <= r_w + 4'd1;
            if (in_last) begin
               r_last  <= (w_p <= 5'd13);
               r_pend  <= (w_p > 5'd13);
               r_defer <= (w_p == 5'd16);
            end
         end else if (w_xfer) begin
            if (r_last) begin
               r_w     <= 4'd0;
               r_cnt   <= 64'd0;
               r_last  <= 1'b0;
               r_pend  <= 1'b0;
               r_defer <= 1'b0;
            end else if (r_pend) begin
               r_last  <= 1'b1;
               r_pend  <= 1'b0;
               r_defer <= 1'b0;
            end
         end
      end
   end

   // Pack buffer words into the block bus, word 0 in the top bits.
   always_comb begin
      blk_data = '0;
      for (int i = 0; i < 16; i++) blk_data[511 - 32*i -: 32] = r_buf[i];
   end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: known padding vectors, stall and reset behaviour.
// Blocks are captured by a monitor on the falling edge and compared against hand-built blocks.
// Inputs are driven 1 time unit after the rising edge.
module tb_sha256_padder;

   logic         sys_clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_data;
   logic         in_last;
   logic [2:0]   in_bytes;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         blk_last;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   logic [512:0] q [$];
   int           qc [$];

   sha256_padder dut (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_bytes  (in_bytes),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_last  (blk_last)
   );

   always #5 sys_clk = ~sys_clk;

   // Cycle counter for back-to-back timing.
   always @(posedge sys_clk) cyc <= cyc + 1;

   // Capture every transferred block.
   always @(negedge sys_clk) begin
      if (!rst && blk_valid && blk_ready) begin
         q.push_back({blk_last, blk_data});
         qc.push_back(cyc);
      end
   end

   task automatic chk_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] wset(input logic [511:0] b, input int i, input logic [31:0] v);
      logic [511:0] r;
      r = b;
      r[511 - 32*i -: 32] = v;
      return r;
   endfunction

   function automatic logic [31:0] pat(input int k);
      logic [7:0] x;
      x = 8'(k + 1);
      return {4{x}};
   endfunction

   function automatic logic [511:0] exp_abc();
      logic [511:0] e;
      e = '0;
      e = wset(e, 0, 32'h61626380);
      e = wset(e, 15, 32'h00000018);
      return e;
   endfunction

   task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] b);
      int n;
      n = 0;
      in_valid = 1'b1; in_data = d; in_last = l; in_bytes = b;
      @(negedge sys_clk);
      while (!in_ready && n < 300) begin
         @(negedge sys_clk);
         n++;
      end
      if (!in_ready) chk_eq("in_ready_timeout", in_ready, 1);
      @(posedge sys_clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_msg(input int nwords, input logic [31:0] last_d, input logic [2:0] last_b);
      for (int k = 0; k < nwords - 1; k++) send_word(pat(k), 1'b0, 3'd4);
      send_word(last_d, 1'b1, last_b);
   endtask

   task automatic wait_blocks(input string tag, input int n);
      int k;
      k = 0;
      while (q.size() < n && k < 300) begin
         @(posedge sys_clk);
         k++;
      end
      #1;
      chk_eq({tag, "_nblk"}, q.size(), n);
   endtask

   task automatic chk_blk(input string tag, input logic [511:0] ed, input logic el);
      logic [512:0] e;
      int c;
      if (q.size() == 0) begin
         chk_eq({tag, "_present"}, q.size(), 1);
         return;
      end
      e = q.pop_front();
      c = qc.pop_front();
      chk_eq({tag, "_data"}, e[511:0], ed);
      chk_eq({tag, "_last"}, e[512], el);
   endtask

   initial begin
      logic [511:0] e;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = 3'd4; blk_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge sys_clk);
      #1;
      chk_eq("rst_in_ready", in_ready, 0);
      chk_eq("rst_blk_valid", blk_valid, 0);
      chk_eq("rst_blk_last", blk_last, 0);
      chk_eq("rst_blk_data", blk_data, 0);
      @(negedge sys_clk);
      rst = 1'b0;
      @(posedge sys_clk);
      #1;
      chk_eq("ready_after_rst", in_ready, 1);

      // "abc"
      send_msg(1, 32'h61626300, 3'd3);
      wait_blocks("abc", 1);
      chk_blk("abc", exp_abc(), 1'b1);

      // Empty message; stale data bits must be masked off
      send_msg(1, 32'hDEADBEEF, 3'd0);
      wait_blocks("empty", 1);
      e = '0; e = wset(e, 0, 32'h80000000);
      chk_blk("empty", e, 1'b1);

      // 56 bytes: marker in word 14, length in a back-to-back extra block
      send_msg(14, pat(13), 3'd4);
      wait_blocks("b56", 2);
      chk_eq("b56_b2b_gap", qc[1] - qc[0], 1);
      e = '0;
      for (int k = 0; k < 14; k++) e = wset(e, k, pat(k));
      e = wset(e, 14, 32'h80000000);
      chk_blk("b56_blk1", e, 1'b0);
      e = '0; e = wset(e, 15, 32'h000001C0);
      chk_blk("b56_blk2", e, 1'b1);

      // 64 bytes: marker deferred into the extra block
      send_msg(16, pat(15), 3'd4);
      wait_blocks("b64", 2);
      chk_eq("b64_b2b_gap", qc[1] - qc[0], 1);
      e = '0;
      for (int k = 0; k < 16; k++) e = wset(e, k, pat(k));
      chk_blk("b64_blk1", e, 1'b0);
      e = '0; e = wset(e, 0, 32'h80000000); e = wset(e, 15, 32'h00000200);
      chk_blk("b64_blk2", e, 1'b1);

      // 60 bytes: marker in word 15
      send_msg(15, pat(14), 3'd4);
      wait_blocks("b60", 2);
      e = '0;
      for (int k = 0; k < 15; k++) e = wset(e, k, pat(k));
      e = wset(e, 15, 32'h80000000);
      chk_blk("b60_blk1", e, 1'b0);
      e = '0; e = wset(e, 15, 32'h000001E0);
      chk_blk("b60_blk2", e, 1'b1);

      // 54 bytes: marker in word 13, length fits in the same block
      send_msg(14, 32'hAABBCCDD, 3'd2);
      wait_blocks("b54", 1);
      e = '0;
      for (int k = 0; k < 13; k++) e = wset(e, k, pat(k));
      e = wset(e, 13, 32'hAABB8000);
      e = wset(e, 15, 32'h000001B0);
      chk_blk("b54", e, 1'b1);
      repeat (20) @(posedge sys_clk);
      #1;
      chk_eq("b54_single", q.size(), 0);

      // Oversize in_bytes saturates to 4
      send_msg(1, 32'h12345678, 3'd7);
      wait_blocks("clamp", 1);
      e = '0; e = wset(e, 0, 32'h12345678); e = wset(e, 1, 32'h80000000); e = wset(e, 15, 32'h00000020);
      chk_blk("clamp", e, 1'b1);

      // One valid byte
      send_msg(1, 32'hAABBCCDD, 3'd1);
      wait_blocks("b1", 1);
      e = '0; e = wset(e, 0, 32'hAA800000); e = wset(e, 15, 32'h00000008);
      chk_blk("b1", e, 1'b1);

      // Stall: block held, pending word not consumed
      blk_ready = 1'b0;
      send_word(32'h61626300, 1'b1, 3'd3);
      in_valid = 1'b1; in_data = 32'h11111111; in_last = 1'b1; in_bytes = 3'd4;
      for (int k = 0; k < 5; k++) begin
         @(negedge sys_clk);
         chk_eq("hold_valid", blk_valid, 1);
         chk_eq("hold_in_ready", in_ready, 0);
         chk_eq("hold_data", blk_data, exp_abc());
         chk_eq("hold_last", blk_last, 1);
         chk_eq("hold_no_xfer", q.size(), 0);
      end
      @(posedge sys_clk);
      #1;
      blk_ready = 1'b1;
      @(posedge sys_clk);
      #1;
      chk_eq("release_xfer", q.size(), 1);
      @(negedge sys_clk);
      chk_eq("release_ready", in_ready, 1);
      @(posedge sys_clk);
      #1;
      in_valid = 1'b0;
      wait_blocks("hold", 2);
      chk_blk("hold_blk1", exp_abc(), 1'b1);
      e = '0; e = wset(e, 0, 32'h11111111); e = wset(e, 1, 32'h80000000); e = wset(e, 15, 32'h00000020);
      chk_blk("hold_blk2", e, 1'b1);

      // Reset mid-message discards partial state
      for (int k = 0; k < 7; k++) send_word(pat(k), 1'b0, 3'd4);
      rst = 1'b1;
      @(negedge sys_clk);
      chk_eq("rstmid_in_ready", in_ready, 0);
      chk_eq("rstmid_blk_valid", blk_valid, 0);
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      rst = 1'b0;
      @(posedge sys_clk);
      #1;
      chk_eq("rstmid_no_block", q.size(), 0);
      send_msg(1, 32'h61626300, 3'd3);
      wait_blocks("rstabc", 1);
      chk_blk("rstabc", exp_abc(), 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
